// File: rtl/coin_pkg.sv
// Shared coin codes, coin values and feeder FSM states for the coin feeder block.
package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A    = 2'b01;
  localparam logic [1:0] COIN_B    = 2'b10;
  localparam logic [1:0] COIN_C    = 2'b11;

  localparam logic [7:0] VALUE_A = 8'd1;
  localparam logic [7:0] VALUE_B = 8'd2;
  localparam logic [7:0] VALUE_C = 8'd5;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } state_t;

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_A:  return VALUE_A;
      COIN_B:  return VALUE_B;
      COIN_C:  return VALUE_C;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hff : sum[7:0];
  endfunction

endpackage

// File: rtl/coin_fifo.sv
// Coin code queue: DEPTH entries (power of two), pointers wrap modulo DEPTH, clear empties it.
module coin_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [1:0]               wdata,
  input  logic                     pop,
  output logic [1:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/coin_feeder.sv
// Queues inserted coins and replays them as one-cycle {i,j} codes separated by GAP idle cycles.
// Optional per-type sent counters (cnt_a/cnt_b/cnt_c) when COIN_FEEDER_STATS_EN is defined.
module coin_feeder
  import coin_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  output logic       coin_ready,
  input  logic       flush,
  output logic       i,
  output logic       j,
  output logic       busy,
  output logic [7:0] sent_value
`ifdef COIN_FEEDER_STATS_EN
  ,
  output logic [7:0] cnt_a,
  output logic [7:0] cnt_b,
  output logic [7:0] cnt_c
`endif
);

  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam logic [3:0]  GAP_M1 = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t       state_q, state_d;
  logic [1:0]   ij_q, ij_d;
  logic [3:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]   value_q, value_d;
  logic         push, pop, go_send;
  logic [1:0]   fifo_rdata;
  logic         fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
`ifdef COIN_FEEDER_STATS_EN
  logic [7:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_c_q, cnt_c_d;
`endif

  assign coin_ready = (fifo_count < CW'(DEPTH));
  assign push       = coin_valid && (coin_type != COIN_NONE) && !fifo_full && !flush;

  coin_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .wdata (coin_type),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    ij_d      = COIN_NONE;
    gap_cnt_d = gap_cnt_q;
    value_d   = value_q;
    pop       = 1'b0;
    go_send   = 1'b0;
`ifdef COIN_FEEDER_STATS_EN
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    cnt_c_d   = cnt_c_q;
`endif
    unique case (state_q)
      IDLE: go_send = !fifo_empty;
      SEND: begin
        if (GAP > 0) begin
          state_d   = HOLD;
          gap_cnt_d = GAP_M1;
        end else begin
          state_d = IDLE;
          go_send = !fifo_empty;
        end
      end
      HOLD: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
          go_send = !fifo_empty;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over any pending pop; the queue is cleared on the same edge.
    if (flush) begin
      state_d = IDLE;
      go_send = 1'b0;
    end
    if (go_send) begin
      pop     = 1'b1;
      state_d = SEND;
      ij_d    = fifo_rdata;
      value_d = sat_add8(value_q, coin_value(fifo_rdata));
`ifdef COIN_FEEDER_STATS_EN
      if (fifo_rdata == COIN_A) cnt_a_d = sat_add8(cnt_a_q, 8'd1);
      if (fifo_rdata == COIN_B) cnt_b_d = sat_add8(cnt_b_q, 8'd1);
      if (fifo_rdata == COIN_C) cnt_c_d = sat_add8(cnt_c_q, 8'd1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ij_q      <= COIN_NONE;
      gap_cnt_q <= '0;
      value_q   <= '0;
`ifdef COIN_FEEDER_STATS_EN
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      cnt_c_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ij_q      <= ij_d;
      gap_cnt_q <= gap_cnt_d;
      value_q   <= value_d;
`ifdef COIN_FEEDER_STATS_EN
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      cnt_c_q   <= cnt_c_d;
`endif
    end
  end

  assign i          = ij_q[1];
  assign j          = ij_q[0];
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign sent_value = value_q;
`ifdef COIN_FEEDER_STATS_EN
  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
  assign cnt_c = cnt_c_q;
`endif

endmodule

// File: tb/tb_coin_feeder.sv
// Self-checking bench: two coin_feeder instances (GAP=1 and GAP=0) share stimulus and are
// compared every cycle against a cooldown-based queue model.
module tb_coin_feeder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, coin_valid, flush;
  logic [1:0] coin_type;
  logic       rdy [2];
  logic       oi [2];
  logic       oj [2];
  logic       busy [2];
  logic [7:0] sent_v [2];
`ifdef COIN_FEEDER_STATS_EN
  logic [7:0] ca [2];
  logic [7:0] cb [2];
  logic [7:0] cc [2];
`endif

  int checks = 0;
  int failures = 0;

  // model state per instance
  int         gaps [2] = '{1, 0};
  logic [1:0] m_q [2][$];
  int         m_blocked [2];
  bit         m_hold [2];
  logic [1:0] m_ij [2];
  int         m_val [2];
  int         m_cnt [2][4];

  always #5 clk = ~clk;

  coin_feeder #(.DEPTH(DEPTH), .GAP(1)) u_dut_g1 (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .coin_ready(rdy[0]), .flush(flush), .i(oi[0]), .j(oj[0]), .busy(busy[0]),
    .sent_value(sent_v[0])
`ifdef COIN_FEEDER_STATS_EN
    , .cnt_a(ca[0]), .cnt_b(cb[0]), .cnt_c(cc[0])
`endif
  );

  coin_feeder #(.DEPTH(DEPTH), .GAP(0)) u_dut_g0 (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .coin_ready(rdy[1]), .flush(flush), .i(oi[1]), .j(oj[1]), .busy(busy[1]),
    .sent_value(sent_v[1])
`ifdef COIN_FEEDER_STATS_EN
    , .cnt_a(ca[1]), .cnt_b(cb[1]), .cnt_c(cc[1])
`endif
  );

  function automatic int worth(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k].delete();
      m_blocked[k] = 0;
      m_hold[k]    = 0;
      m_ij[k]      = 2'b00;
      m_val[k]     = 0;
      for (int c = 0; c < 4; c++) m_cnt[k][c] = 0;
    end
  endtask

  // Each sent coin blocks the next GAP pop opportunities; pops use the pre-edge queue.
  task automatic model_edge(input logic v, input logic [1:0] t, input logic f);
    for (int k = 0; k < 2; k++) begin
      bit         can_push;
      logic [1:0] c;
      can_push = v && (t != 2'b00) && (m_q[k].size() < DEPTH) && !f;
      if (f) begin
        m_q[k].delete();
        m_blocked[k] = 0;
        m_hold[k]    = 0;
        m_ij[k]      = 2'b00;
      end else if (m_blocked[k] > 0) begin
        m_blocked[k]--;
        m_hold[k] = 1;
        m_ij[k]   = 2'b00;
      end else begin
        m_hold[k] = 0;
        if (m_q[k].size() > 0) begin
          c            = m_q[k].pop_front();
          m_ij[k]      = c;
          m_blocked[k] = gaps[k];
          m_val[k]     = (m_val[k] + worth(c) > 255) ? 255 : m_val[k] + worth(c);
          if (m_cnt[k][c] < 255) m_cnt[k][c]++;
        end else begin
          m_ij[k] = 2'b00;
        end
      end
      if (can_push) m_q[k].push_back(t);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; flush = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Drives one cycle of stimulus and compares both instances against the model.
  task automatic cycle(input logic v, input logic [1:0] t, input logic f);
    logic exp_busy;
    coin_valid = v; coin_type = t; flush = f;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdy[k] !== (m_q[k].size() < DEPTH)) begin
        failures++;
        $display("FAIL coin_ready[%0d] t=%0t got=%b exp=%b", k, $time, rdy[k], m_q[k].size() < DEPTH);
      end
    end
    @(posedge clk);
    model_edge(v, t, f);
    #1;
    coin_valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_busy = (m_q[k].size() != 0) || (m_ij[k] != 2'b00) || m_hold[k];
      checks++;
      if ({oi[k], oj[k]} !== m_ij[k]) begin
        failures++;
        $display("FAIL ij[%0d] t=%0t got=%b exp=%b", k, $time, {oi[k], oj[k]}, m_ij[k]);
      end
      checks++;
      if (busy[k] !== exp_busy) begin
        failures++;
        $display("FAIL busy[%0d] t=%0t got=%b exp=%b", k, $time, busy[k], exp_busy);
      end
      checks++;
      if (sent_v[k] !== 8'(m_val[k])) begin
        failures++;
        $display("FAIL sent_value[%0d] t=%0t got=%0d exp=%0d", k, $time, sent_v[k], m_val[k]);
      end
`ifdef COIN_FEEDER_STATS_EN
      checks++;
      if (ca[k] !== 8'(m_cnt[k][1]) || cb[k] !== 8'(m_cnt[k][2]) || cc[k] !== 8'(m_cnt[k][3])) begin
        failures++;
        $display("FAIL stats[%0d] t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d", k, $time,
                 ca[k], cb[k], cc[k], m_cnt[k][1], m_cnt[k][2], m_cnt[k][3]);
      end
`endif
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({oi[k], oj[k], busy[k], rdy[k]} !== 4'b0001 || sent_v[k] !== 8'd0) begin
        failures++;
        $display("FAIL reset_state[%0d] got ij=%b busy=%b rdy=%b sv=%0d exp ij=00 busy=0 rdy=1 sv=0",
                 k, {oi[k], oj[k]}, busy[k], rdy[k], sent_v[k]);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    cycle(1'b1, 2'b01, 1'b0);
    checks++;
    if ({oi[0], oj[0]} !== 2'b00) begin
      failures++; $display("FAIL single_early got=%b exp=00", {oi[0], oj[0]});
    end
    cycle(1'b0, 2'b00, 1'b0);
    checks++;
    if ({oi[0], oj[0]} !== 2'b01) begin
      failures++; $display("FAIL single_send got=%b exp=01", {oi[0], oj[0]});
    end
    cycle(1'b0, 2'b00, 1'b0);
    checks++;
    if ({oi[0], oj[0], busy[0]} !== 3'b001) begin
      failures++; $display("FAIL single_hold got ij/busy=%b exp=001", {oi[0], oj[0], busy[0]});
    end
    cycle(1'b0, 2'b00, 1'b0);
    checks++;
    if (busy[0] !== 1'b0 || sent_v[0] !== 8'd1) begin
      failures++; $display("FAIL single_done got busy=%b sv=%0d exp busy=0 sv=1", busy[0], sent_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] codes [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    logic [1:0] log_ij [12];
    apply_reset();
    for (int n = 0; n < 12; n++) begin
      if (n < 4) cycle(1'b1, codes[n], 1'b0);
      else cycle(1'b0, 2'b00, 1'b0);
      log_ij[n] = {oi[0], oj[0]};
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (log_ij[2 * n + 1] !== codes[n] || log_ij[2 * n + 2] !== 2'b00) begin
        failures++;
        $display("FAIL b2b_order[%0d] got=%b,%b exp=%b,00", n, log_ij[2 * n + 1], log_ij[2 * n + 2], codes[n]);
      end
    end
    checks++;
    if (sent_v[0] !== 8'd9 || sent_v[1] !== 8'd9) begin
      failures++; $display("FAIL b2b_value got=%0d/%0d exp=9/9", sent_v[0], sent_v[1]);
    end
  endtask

  task automatic test_gap0();
    apply_reset();
    cycle(1'b1, 2'b10, 1'b0);
    cycle(1'b1, 2'b10, 1'b0);
    checks++;
    if ({oi[1], oj[1]} !== 2'b10) begin
      failures++; $display("FAIL gap0_first got=%b exp=10", {oi[1], oj[1]});
    end
    cycle(1'b0, 2'b00, 1'b0);
    checks++;
    if ({oi[1], oj[1]} !== 2'b10) begin
      failures++; $display("FAIL gap0_second got=%b exp=10", {oi[1], oj[1]});
    end
    cycle(1'b0, 2'b00, 1'b0);
    checks++;
    if ({oi[1], oj[1], busy[1]} !== 3'b000) begin
      failures++; $display("FAIL gap0_idle got ij/busy=%b exp=000", {oi[1], oj[1], busy[1]});
    end
  endtask

  task automatic test_flush();
    logic [1:0] codes [5] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b11};
    apply_reset();
    for (int n = 0; n < 5; n++) cycle(1'b1, codes[n], 1'b0);
    // GAP=1 instance: A and B sent, now in HOLD with C,A,C still queued
    checks++;
    if ({oi[0], oj[0]} !== 2'b00 || busy[0] !== 1'b1 || sent_v[0] !== 8'd3) begin
      failures++; $display("FAIL flush_pre got ij=%b busy=%b sv=%0d exp 00/1/3", {oi[0], oj[0]}, busy[0], sent_v[0]);
    end
    cycle(1'b0, 2'b00, 1'b1);
    checks++;
    if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
      failures++; $display("FAIL flush_busy got=%b%b exp=00", busy[0], busy[1]);
    end
    for (int n = 0; n < 5; n++) cycle(1'b0, 2'b00, 1'b0);
    checks++;
    if (sent_v[0] !== 8'd3 || {oi[0], oj[0]} !== 2'b00) begin
      failures++; $display("FAIL flush_after got sv=%0d ij=%b exp sv=3 ij=00", sent_v[0], {oi[0], oj[0]});
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int n = 0; n < 9; n++) cycle(1'b1, 2'b11, 1'b0);
    checks++;
    if (rdy[0] !== 1'b0) begin
      failures++; $display("FAIL full_ready got=%b exp=0", rdy[0]);
    end
    for (int n = 0; n < 12; n++) cycle(1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_saturate();
    int n = 0;
    int guard = 0;
    apply_reset();
    while (n < 52 && guard < 1000) begin
      if (m_q[0].size() < DEPTH) n++;
      cycle(1'b1, 2'b11, 1'b0);
      guard++;
    end
    checks++;
    if (n != 52) begin
      failures++; $display("FAIL sat_budget got=%0d pushes exp=52", n);
    end
    for (int k = 0; k < 20; k++) cycle(1'b0, 2'b00, 1'b0);
    checks++;
    if (sent_v[0] !== 8'd255) begin
      failures++; $display("FAIL sat_value got=%0d exp=255", sent_v[0]);
    end
`ifdef COIN_FEEDER_STATS_EN
    checks++;
    if (cc[0] !== 8'd52) begin
      failures++; $display("FAIL sat_cnt_c got=%0d exp=52", cc[0]);
    end
`endif
  endtask

  task automatic test_reset_mid_send();
    apply_reset();
    cycle(1'b1, 2'b01, 1'b0);
    cycle(1'b1, 2'b10, 1'b0);
    cycle(1'b1, 2'b11, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({oi[k], oj[k], busy[k], rdy[k]} !== 4'b0001 || sent_v[k] !== 8'd0) begin
        failures++;
        $display("FAIL reset_mid[%0d] got ij=%b busy=%b rdy=%b sv=%0d exp 00/0/1/0",
                 k, {oi[k], oj[k]}, busy[k], rdy[k], sent_v[k]);
      end
    end
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 4; n++) cycle(1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 24) == 0));
    end
  endtask

  initial begin
    reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; flush = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_gap0();
    test_flush();
    test_full();
    test_saturate();
    test_reset_mid_send();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
